// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: port addresses, display modes,
// status bit layout, prefetch request format and table-base decoding.
package vdp_pkg;

  localparam logic [7:0] DATA_PORT_DEF = 8'hBE;
  localparam logic [7:0] CTRL_PORT_DEF = 8'hBF;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_G1   = 2'd1,
    MODE_G2   = 2'd2,
    MODE_MC   = 2'd3
  } vdp_mode_t;

  localparam int ST_INT  = 7;
  localparam int ST_5S   = 6;
  localparam int ST_COLL = 5;

  typedef struct packed {
    logic        load;
    logic [13:0] addr;
    logic        write;
    logic [7:0]  wdata;
    logic        fetch;
  } pf_req_t;

  typedef struct packed {
    logic [13:0] name;
    logic [13:0] color;
    logic [13:0] font;
    logic [13:0] spr_attr;
    logic [13:0] spr_pat;
  } tbl_bases_t;

  function automatic vdp_mode_t decode_mode(input logic [7:0] r0, input logic [7:0] r1);
    vdp_mode_t m;
    if (r1[3])      m = MODE_MC;
    else if (r0[1]) m = MODE_G2;
    else if (r1[4]) m = MODE_TEXT;
    else            m = MODE_G1;
    return m;
  endfunction

  // Bases are 14-bit VRAM addresses; bits shifted beyond 3FFF are dropped.
  function automatic tbl_bases_t decode_bases(input vdp_mode_t m,
                                              input logic [7:0] r2, input logic [7:0] r3,
                                              input logic [7:0] r4, input logic [7:0] r5,
                                              input logic [7:0] r6);
    tbl_bases_t b;
    b.name     = {r2[3:0], 10'h000};
    b.color    = (m == MODE_G2) ? {r3[7], 13'h0000} : {r3, 6'h00};
    b.font     = (m == MODE_G2) ? {r4[2], 13'h0000} : {r4[2:0], 11'h000};
    b.spr_attr = {r5[6:0], 7'h00};
    b.spr_pat  = {r6[2:0], 11'h000};
    return b;
  endfunction

endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU I/O bus as seen by the VDP: address, active-low strobes, write and read data.
interface vdp_cpu_port_if;
  logic [7:0] io_addr;
  logic       io_wr_n;
  logic       io_rd_n;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output io_addr, io_wr_n, io_rd_n, din, input dout);
  modport slave  (input io_addr, io_wr_n, io_rd_n, din, output dout);
endinterface

// File: rtl/vdp_prefetch.sv
// VRAM pointer, read-ahead buffer and the prefetch sequencer; also issues CPU VRAM writes.
//  state     | meaning
//  S_IDLE    | accept pointer load / write / fetch (pending one first)
//  S_FETCH   | vram_re high, vram_addr = pointer
//  S_CAPTURE | buffer <= vram_rdata, pointer + 1
module vdp_prefetch
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  pf_req_t     req,
  input  logic [7:0]  vram_rdata,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  output logic [7:0]  rd_buf
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE} state_t;

  state_t      state, state_nxt;
  pf_req_t     pend, act;
  logic        pend_vld;
  logic        req_vld;
  logic [13:0] ptr;
  logic [13:0] wr_addr;

  assign req_vld = req.load | req.write | req.fetch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    act       = '0;
    vram_re   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_vld)     act = pend;
        else if (req_vld) act = req;
        if (act.fetch) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        vram_re   = 1'b1;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // A request landing while the sequencer is busy is held and replayed from IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (req_vld && (state != S_IDLE || pend_vld)) begin
      pend     <= req;
      pend_vld <= 1'b1;
    end else if (state == S_IDLE) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      rd_buf     <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      wr_addr    <= '0;
    end else begin
      vram_we <= act.write;
      if (act.write) begin
        vram_wdata <= act.wdata;
        wr_addr    <= ptr;
        rd_buf     <= act.wdata;
        ptr        <= ptr + 14'd1;
      end
      if (act.load) ptr <= act.addr;
      if (state == S_CAPTURE) begin
        rd_buf <= vram_rdata;
        ptr    <= ptr + 14'd1;
      end
    end
  end

  // The pointer has already advanced during a write pulse, so present the latched one.
  assign vram_addr = vram_we ? wr_addr : ptr;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side front end of the VDP: port decode, two-byte control latch, R0-R7,
// status flags and NMI; VRAM pointer and read-ahead live in vdp_prefetch.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter logic [7:0] DATA_PORT = DATA_PORT_DEF,
  parameter logic [7:0] CTRL_PORT = CTRL_PORT_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_en,
  vdp_cpu_port_if.slave bus,
  output logic [13:0]   vram_addr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic          vram_re,
  input  logic [7:0]    vram_rdata,
  input  logic          frame_int,
  input  logic          sprite_coll,
  input  logic          too_many,
  input  logic [4:0]    sprite5,
  output logic [1:0]    mode,
  output logic [13:0]   name_base,
  output logic [13:0]   color_base,
  output logic [13:0]   font_base,
  output logic [13:0]   spr_attr_base,
  output logic [13:0]   spr_pat_base,
  output logic [7:0]    r1,
  output logic [7:0]    r7,
  output logic          nmi_n
);

  logic       wr_prev, rd_prev;
  logic       wr_start, rd_start, rd_release;
  logic       is_data, is_ctrl;
  logic       rd_data_act, rd_stat_act;
  logic       toggle;
  logic [7:0] first_byte;
  logic [7:0] regs [0:7];
  logic       int_flag, coll_flag, stat_clr;
  logic [7:0] dout_q, rd_buf, status;
  pf_req_t    pf_req;
  vdp_mode_t  mode_dec;
  tbl_bases_t bases;

  assign is_data    = (bus.io_addr == DATA_PORT);
  assign is_ctrl    = (bus.io_addr == CTRL_PORT);
  assign wr_start   = clk_en & ~bus.io_wr_n & wr_prev;
  assign rd_start   = clk_en & ~bus.io_rd_n & rd_prev;
  assign rd_release = clk_en & bus.io_rd_n & ~rd_prev;
  assign stat_clr   = rd_release & rd_stat_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
    end else if (clk_en) begin
      wr_prev <= bus.io_wr_n;
      rd_prev <= bus.io_rd_n;
    end
  end

  // Which port a read addressed is remembered until the strobe is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_act <= 1'b0;
      rd_stat_act <= 1'b0;
    end else if (rd_start) begin
      rd_data_act <= is_data;
      rd_stat_act <= is_ctrl;
    end else if (rd_release) begin
      rd_data_act <= 1'b0;
      rd_stat_act <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle     <= 1'b0;
      first_byte <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_start && is_ctrl) begin
      if (!toggle) begin
        first_byte <= bus.din;
        toggle     <= 1'b1;
      end else begin
        toggle <= 1'b0;
        if (bus.din[7]) regs[bus.din[2:0]] <= first_byte;
      end
    end else if ((wr_start && is_data) || (rd_start && (is_data || is_ctrl))) begin
      toggle <= 1'b0;
    end
  end

  always_comb begin
    status          = '0;
    status[ST_INT]  = int_flag;
    status[ST_5S]   = too_many;
    status[ST_COLL] = coll_flag;
    status[4:0]     = too_many ? sprite5 : 5'h1F;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q    <= '0;
      int_flag  <= 1'b0;
      coll_flag <= 1'b0;
    end else begin
      if (rd_start && is_data)      dout_q <= rd_buf;
      else if (rd_start && is_ctrl) dout_q <= status;
      int_flag  <= frame_int   | (int_flag  & ~stat_clr);
      coll_flag <= sprite_coll | (coll_flag & ~stat_clr);
    end
  end

  assign bus.dout = dout_q;

  always_comb begin
    pf_req = '0;
    if (wr_start && is_ctrl && toggle && !bus.din[7]) begin
      pf_req.load  = 1'b1;
      pf_req.addr  = {bus.din[5:0], first_byte};
      pf_req.fetch = ~bus.din[6];
    end else if (wr_start && is_data) begin
      pf_req.write = 1'b1;
      pf_req.wdata = bus.din;
    end else if (rd_release && rd_data_act) begin
      pf_req.fetch = 1'b1;
    end
  end

  vdp_prefetch u_prefetch (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (pf_req),
    .vram_rdata (vram_rdata),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_re    (vram_re),
    .rd_buf     (rd_buf)
  );

  assign mode_dec      = decode_mode(regs[0], regs[1]);
  assign bases         = decode_bases(mode_dec, regs[2], regs[3], regs[4], regs[5], regs[6]);
  assign mode          = mode_dec;
  assign name_base     = bases.name;
  assign color_base    = bases.color;
  assign font_base     = bases.font;
  assign spr_attr_base = bases.spr_attr;
  assign spr_pat_base  = bases.spr_pat;
  assign r1            = regs[1];
  assign r7            = regs[7];
  assign nmi_n         = ~(int_flag & regs[1][5]);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a behavioural VRAM (1-clk read latency).
module tb_vdp_cpu_port;

  localparam logic [7:0] DP = 8'hBE;
  localparam logic [7:0] CP = 8'hBF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we, vram_re;
  logic [7:0]  vram_rdata;
  logic        frame_int, sprite_coll, too_many;
  logic [4:0]  sprite5;
  logic [1:0]  mode;
  logic [13:0] name_base, color_base, font_base, spr_attr_base, spr_pat_base;
  logic [7:0]  r1, r7;
  logic        nmi_n;
  logic [7:0]  rd;

  int n_tests = 0;
  int n_fail  = 0;

  vdp_cpu_port_if bus ();

  vdp_cpu_port dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clk_en        (clk_en),
    .bus           (bus),
    .vram_addr     (vram_addr),
    .vram_wdata    (vram_wdata),
    .vram_we       (vram_we),
    .vram_re       (vram_re),
    .vram_rdata    (vram_rdata),
    .frame_int     (frame_int),
    .sprite_coll   (sprite_coll),
    .too_many      (too_many),
    .sprite5       (sprite5),
    .mode          (mode),
    .name_base     (name_base),
    .color_base    (color_base),
    .font_base     (font_base),
    .spr_attr_base (spr_attr_base),
    .spr_pat_base  (spr_pat_base),
    .r1            (r1),
    .r7            (r7),
    .nmi_n         (nmi_n)
  );

  always #5 clk = ~clk;

  logic [7:0] vram [0:16383];
  always @(posedge clk) begin
    if (vram_we) vram[vram_addr] <= vram_wdata;
    if (vram_re) vram_rdata <= vram[vram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.io_addr = a;
    bus.din     = d;
    bus.io_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.io_wr_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic io_rd(input logic [7:0] a, input logic int_at_release, output logic [7:0] d);
    @(negedge clk);
    bus.io_addr = a;
    bus.io_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    d           = bus.dout;
    bus.io_rd_n = 1'b1;
    frame_int   = int_at_release;
    @(negedge clk);
    frame_int   = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ctrl2(input logic [7:0] b0, input logic [7:0] b1);
    io_wr(CP, b0);
    io_wr(CP, b1);
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame_int = 1'b1;
    @(negedge clk) frame_int = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    clk_en      = 1'b1;
    bus.io_addr = 8'h00;
    bus.io_wr_n = 1'b1;
    bus.io_rd_n = 1'b1;
    bus.din     = 8'h00;
    frame_int   = 1'b0;
    sprite_coll = 1'b0;
    too_many    = 1'b0;
    sprite5     = 5'h00;
    repeat (3) @(negedge clk);

    chk("rst_dout",  32'(bus.dout),  32'h00);
    chk("rst_we",    32'(vram_we),   32'h0);
    chk("rst_re",    32'(vram_re),   32'h0);
    chk("rst_nmi",   32'(nmi_n),     32'h1);
    chk("rst_addr",  32'(vram_addr), 32'h0000);
    chk("rst_r1",    32'(r1),        32'h00);
    chk("rst_mode",  32'(mode),      32'h1);
    chk("rst_name",  32'(name_base), 32'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // VRAM writes through the data port
    ctrl2(8'h00, 8'h40);
    io_wr(DP, 8'hAA);
    io_wr(DP, 8'h55);
    chk("wr_vram0", 32'(vram[14'h0000]), 32'hAA);
    chk("wr_vram1", 32'(vram[14'h0001]), 32'h55);
    chk("wr_ptr",   32'(vram_addr),      32'h0002);

    // register file and table bases
    ctrl2(8'hC2, 8'h81);
    chk("r1_c2",    32'(r1),   32'hC2);
    chk("mode_g1",  32'(mode), 32'h1);
    ctrl2(8'h06, 8'h82);
    chk("name_base", 32'(name_base), 32'h1800);
    ctrl2(8'hFF, 8'h83);
    ctrl2(8'h07, 8'h84);
    ctrl2(8'hFF, 8'h85);
    ctrl2(8'h05, 8'h86);
    ctrl2(8'hF4, 8'h87);
    chk("color_g1",  32'(color_base),    32'h3FC0);
    chk("font_g1",   32'(font_base),     32'h3800);
    chk("spr_attr",  32'(spr_attr_base), 32'h3F80);
    chk("spr_pat",   32'(spr_pat_base),  32'h2800);
    chk("r7",        32'(r7),            32'hF4);
    ctrl2(8'h02, 8'h80);
    chk("mode_g2",   32'(mode),       32'h2);
    chk("color_g2",  32'(color_base), 32'h2000);
    chk("font_g2",   32'(font_base),  32'h2000);
    ctrl2(8'h18, 8'h81);
    chk("mode_mc",   32'(mode), 32'h3);
    ctrl2(8'h00, 8'h80);
    ctrl2(8'h10, 8'h81);
    chk("mode_text", 32'(mode), 32'h0);

    // read-ahead
    ctrl2(8'h00, 8'h41);
    io_wr(DP, 8'h12);
    io_wr(DP, 8'h34);
    ctrl2(8'h00, 8'h01);
    io_rd(DP, 1'b0, rd);
    chk("rd_first",  32'(rd),        32'h12);
    chk("rd_ptr1",   32'(vram_addr), 32'h0102);
    io_rd(DP, 1'b0, rd);
    chk("rd_second", 32'(rd),        32'h34);
    chk("rd_ptr2",   32'(vram_addr), 32'h0103);

    // pointer wrap
    ctrl2(8'hFF, 8'h7F);
    chk("ptr_3fff",  32'(vram_addr), 32'h3FFF);
    io_wr(DP, 8'h77);
    chk("wrap_data", 32'(vram[14'h3FFF]), 32'h77);
    chk("wrap_ptr",  32'(vram_addr),      32'h0000);

    // interrupt flag, NMI and status
    ctrl2(8'h20, 8'h81);
    chk("nmi_idle", 32'(nmi_n), 32'h1);
    pulse_frame();
    chk("nmi_set",  32'(nmi_n), 32'h0);
    io_rd(CP, 1'b0, rd);
    chk("stat_int", 32'(rd),    32'h9F);
    chk("nmi_clr",  32'(nmi_n), 32'h1);
    too_many = 1'b1;
    sprite5  = 5'h0A;
    @(negedge clk) sprite_coll = 1'b1;
    @(negedge clk) sprite_coll = 1'b0;
    io_rd(CP, 1'b0, rd);
    chk("stat_coll",  32'(rd), 32'h6A);
    io_rd(CP, 1'b0, rd);
    chk("stat_coll2", 32'(rd), 32'h4A);
    too_many = 1'b0;
    pulse_frame();
    io_rd(CP, 1'b1, rd);
    chk("stat_race",   32'(rd),    32'h9F);
    chk("nmi_setwins", 32'(nmi_n), 32'h0);
    io_rd(CP, 1'b0, rd);
    chk("stat_again",  32'(rd),    32'h9F);
    chk("nmi_clr2",    32'(nmi_n), 32'h1);

    // a status read resets the half-written control pair
    io_wr(CP, 8'h34);
    io_rd(CP, 1'b0, rd);
    chk("stat_plain", 32'(rd), 32'h1F);
    ctrl2(8'h00, 8'h41);
    chk("tog_ptr",  32'(vram_addr), 32'h0100);
    chk("tog_r1",   32'(r1),        32'h20);
    chk("tog_r7",   32'(r7),        32'hF4);
    chk("tog_name", 32'(name_base), 32'h1800);

    // strobes without clk_en and foreign addresses are ignored
    @(negedge clk) clk_en = 1'b0;
    io_wr(DP, 8'h99);
    clk_en = 1'b1;
    io_wr(8'hBD, 8'h99);
    chk("ign_data", 32'(vram[14'h0100]), 32'h12);
    chk("ign_ptr",  32'(vram_addr),      32'h0100);

    // reset in the middle of a prefetch
    io_wr(CP, 8'h00);
    @(negedge clk);
    bus.io_addr = CP;
    bus.din     = 8'h02;
    bus.io_wr_n = 1'b0;
    @(negedge clk);
    chk("pf_re",   32'(vram_re),   32'h1);
    chk("pf_addr", 32'(vram_addr), 32'h0200);
    reset_n = 1'b0;
    #1;
    chk("arst_re",   32'(vram_re),   32'h0);
    chk("arst_addr", 32'(vram_addr), 32'h0000);
    chk("arst_r1",   32'(r1),        32'h00);
    chk("arst_nmi",  32'(nmi_n),     32'h1);
    bus.io_wr_n = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_drop", 32'(vram_re),   32'h0);
    chk("arst_ptr",  32'(vram_addr), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
